// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// A key code is the row index in the upper bits and the column index in the lower bits.
package keypad_scanner_pkg;

  localparam int KEY_W = 4;
  localparam int ROW_W = 2;
  localparam int COL_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, CANDIDATE, PRESSED, RELEASE} state_t;
  typedef enum logic [1:0] {EMPTY, SINGLE, MULTI} frame_t;

  function automatic logic [KEY_W-1:0] key_code_of(input logic [ROW_W-1:0] row_idx,
                                                   input logic [COL_W-1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/keypad_frame_collector.sv
// Drives the keypad columns, synchronises the rows and reduces each four-column
// scan frame to EMPTY / SINGLE(code) / MULTI, reported on the last column tick.
module keypad_frame_collector
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic             frame_end,
  output frame_t           frame_res,
  output logic [KEY_W-1:0] frame_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [COL_W-1:0] col_idx_reg;
  logic [3:0]       row_meta_reg;
  logic [3:0]       row_sync_reg;
  logic [1:0]       hits_reg;
  logic [KEY_W-1:0] code_reg;

  logic             tick;
  logic [3:0]       low;
  logic [2:0]       n_low;
  logic [ROW_W-1:0] row_idx_s;
  logic [2:0]       hits_sum;
  logic [1:0]       hits_next;
  logic [KEY_W-1:0] code_next;

  assign tick      = (div_reg == DIV_LAST);
  assign low       = ~row_sync_reg;
  assign col       = ~(4'b0001 << col_idx_reg);
  assign frame_end = tick && (col_idx_reg == COL_W'(3));

  always_comb begin
    n_low     = 3'd0;
    row_idx_s = '0;
    for (int r = 0; r < 4; r++) begin
      if (low[r]) begin
        n_low     = n_low + 3'd1;
        row_idx_s = ROW_W'(r);
      end
    end
    // Hit count saturates at 2: anything beyond one press in a frame is MULTI.
    hits_sum  = {1'b0, hits_reg} + n_low;
    hits_next = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_next = (n_low == 3'd1) ? key_code_of(row_idx_s, col_idx_reg) : code_reg;
    frame_code = code_next;
    case (hits_next)
      2'd0:    frame_res = EMPTY;
      2'd1:    frame_res = SINGLE;
      default: frame_res = MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg      <= '0;
      col_idx_reg  <= '0;
      row_meta_reg <= 4'b1111;
      row_sync_reg <= 4'b1111;
      hits_reg     <= '0;
      code_reg     <= '0;
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
      div_reg      <= tick ? '0 : div_reg + DIV_W'(1);
      if (tick) begin
        col_idx_reg <= col_idx_reg + COL_W'(1);
        if (frame_end) begin
          hits_reg <= '0;
          code_reg <= '0;
        end else begin
          hits_reg <= hits_next;
          code_reg <= code_next;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: frame-level debounce FSM that emits one
// key_valid strobe per accepted press and holds key_held until release.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE);

  logic             frame_end;
  frame_t           frame_res;
  logic [KEY_W-1:0] frame_code;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [KEY_W-1:0] cand_reg, cand_next;
  logic [KEY_W-1:0] code_reg, code_next;
  logic             valid_reg, valid_next;
  logic             held_reg, held_next;

  keypad_frame_collector #(.SCAN_DIV(SCAN_DIV)) u_collector (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .frame_end  (frame_end),
    .frame_res  (frame_res),
    .frame_code (frame_code)
  );

  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    code_next  = code_reg;
    valid_next = 1'b0;
    held_next  = held_reg;
    if (frame_end) begin
      case (state_reg)
        IDLE: begin
          if (frame_res == SINGLE) begin
            cand_next = frame_code;
            if (DEB_CNT <= CNT_W'(1)) begin
              state_next = PRESSED;
              cnt_next   = '0;
              code_next  = frame_code;
              valid_next = 1'b1;
              held_next  = 1'b1;
            end else begin
              state_next = CANDIDATE;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        CANDIDATE: begin
          if (frame_res == SINGLE && frame_code == cand_reg) begin
            if (cnt_inc >= DEB_CNT) begin
              state_next = PRESSED;
              cnt_next   = '0;
              code_next  = cand_reg;
              valid_next = 1'b1;
              held_next  = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end else if (frame_res == SINGLE) begin
            cand_next = frame_code;
            cnt_next  = CNT_W'(1);
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        PRESSED: begin
          if (frame_res == EMPTY) begin
            if (DEB_CNT <= CNT_W'(1)) begin
              state_next = IDLE;
              cnt_next   = '0;
              held_next  = 1'b0;
            end else begin
              state_next = RELEASE;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (frame_res == EMPTY) begin
            if (cnt_inc >= DEB_CNT) begin
              state_next = IDLE;
              cnt_next   = '0;
              held_next  = 1'b0;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            // Contact bounce while releasing: the key is still down, no new strobe.
            state_next = PRESSED;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cand_reg  <= '0;
      code_reg  <= '0;
      valid_reg <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
      code_reg  <= code_next;
      valid_reg <= valid_next;
      held_reg  <= held_next;
    end
  end

  assign key_code  = code_reg;
  assign key_valid = valid_reg;
  assign key_held  = held_reg;

endmodule
